// File: rtl/fir_coeff_loader_if.sv
// Coefficient-update bus between the host/control path and the FIR coefficient loader.
// The bus carries the load control (start, abort), the serial coefficient stream (s_valid,
// s_ready, s_coeff) and the loader outputs (coeff[], update_coeff, busy, err).
// Modports:
//   master - host side: drives start, abort, s_valid, s_coeff; observes the loader outputs.
//   slave  - loader side: the reverse.
interface fir_coeff_loader_if #(
  parameter int unsigned NUM_TAPS = 41,
  parameter int unsigned COEFF_W  = 16
);
  logic               start;
  logic               abort;
  logic               s_valid;
  logic               s_ready;
  logic [COEFF_W-1:0] s_coeff;
  logic [COEFF_W-1:0] coeff [NUM_TAPS-1:0];
  logic               update_coeff;
  logic               busy;
  logic               err;

  modport master (
    output start, abort, s_valid, s_coeff,
    input  s_ready, coeff, update_coeff, busy, err
  );

  modport slave (
    input  start, abort, s_valid, s_coeff,
    output s_ready, coeff, update_coeff, busy, err
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader: collects NUM_TAPS coefficients from a valid/ready stream into a shadow
// bank and commits the complete bank to coeff[] with a single-cycle update_coeff strobe. Partial
// or aborted loads never disturb the active bank.
//
// Ports:
//   clk_i    - system clock, rising edge
//   reset_i  - synchronous, active-high reset
//   bus      - fir_coeff_loader_if.slave: start/abort control, s_valid/s_ready/s_coeff beats,
//              coeff[] active bank, update_coeff strobe, busy, err
//
// Optional feature macro: FIR_COEFF_CHECKSUM_EN. When defined, one extra beat after the last tap
// carries a 16-bit checksum (sum of coefficients mod 2^16); a match commits, a mismatch pulses err
// and drops the load. When undefined, err is tied low and the last tap commits directly.
module fir_coeff_loader #(
  parameter int unsigned NUM_TAPS = 41,
  parameter int unsigned COEFF_W  = 16
) (
  input logic                clk_i,
  input logic                reset_i,
  fir_coeff_loader_if.slave  bus
);

  localparam int unsigned    IdxW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck
  } state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [COEFF_W-1:0] shadow_q [NUM_TAPS-1:0];
  logic [COEFF_W-1:0] shadow_d [NUM_TAPS-1:0];
  logic [COEFF_W-1:0] coeff_q  [NUM_TAPS-1:0];
  logic [COEFF_W-1:0] coeff_d  [NUM_TAPS-1:0];
  logic               update_q, update_d;
  logic               s_ready;
  logic               hs;

`ifdef FIR_COEFF_CHECKSUM_EN
  logic [15:0]        sum_q, sum_d;
  logic               err_q, err_d;
`endif

  assign s_ready = (state_q == StLoad) || (state_q == StCheck);
  assign hs      = bus.s_valid && s_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    coeff_d  = coeff_q;
    update_d = 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
    sum_d    = sum_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        // start together with abort keeps the loader idle
        if (bus.start && !bus.abort) begin
          state_d = StLoad;
          idx_d   = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLoad: begin
        if (bus.abort) begin
          // abort beats a simultaneous final handshake: nothing commits
          state_d = StIdle;
        end else if (hs) begin
          shadow_d[idx_q] = bus.s_coeff;
`ifdef FIR_COEFF_CHECKSUM_EN
          sum_d = sum_q + 16'(bus.s_coeff);
`endif
          if (idx_q == LastIdx) begin
`ifdef FIR_COEFF_CHECKSUM_EN
            state_d = StCheck;
`else
            // final beat is merged straight into the committed bank
            state_d  = StIdle;
            coeff_d  = shadow_d;
            update_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
`ifdef FIR_COEFF_CHECKSUM_EN
      StCheck: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (hs) begin
          state_d = StIdle;
          if (16'(bus.s_coeff) == sum_q) begin
            coeff_d  = shadow_q;
            update_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      shadow_q <= '{default: '0};
      coeff_q  <= '{default: '0};
      update_q <= 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
      sum_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      coeff_q  <= coeff_d;
      update_q <= update_d;
`ifdef FIR_COEFF_CHECKSUM_EN
      sum_q    <= sum_d;
      err_q    <= err_d;
`endif
    end
  end

  assign bus.s_ready      = s_ready;
  assign bus.coeff        = coeff_q;
  assign bus.update_coeff = update_q;
  assign bus.busy         = (state_q != StIdle);
`ifdef FIR_COEFF_CHECKSUM_EN
  assign bus.err          = err_q;
`else
  assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Testbench for fir_coeff_loader: table of load scenarios plus hand-written corner sequences.
module tb_fir_coeff_loader;

  localparam int unsigned NT = 41;
  localparam int unsigned CW = 16;

  logic clk;
  logic reset;

  fir_coeff_loader_if #(.NUM_TAPS(NT), .COEFF_W(CW)) bus ();

  fir_coeff_loader #(.NUM_TAPS(NT), .COEFF_W(CW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] first;      // value of tap 0
    logic [15:0] step;       // increment per tap
    bit          gap;        // idle cycle before every beat
    int          abort_k;    // beat index where abort happens
    int          abort_mode; // 0 none, 1 abort instead of beat k, 2 abort with beat k
    bit          exp_commit;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] exp_bank [NT];
  int          n_cmp;
  int          n_fail;
  int          upd_cnt;
  int          err_cnt;

  always @(negedge clk) begin
    if (bus.update_coeff === 1'b1) upd_cnt++;
    if (bus.err === 1'b1) err_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, summary forced");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bank(input string name);
    int bad;
    bad = -1;
    for (int k = 0; k < NT; k++)
      if (bad < 0 && bus.coeff[k] !== exp_bank[k]) bad = k;
    n_cmp++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: tap %0d got %0h, expected %0h", name, bad, bus.coeff[bad],
               exp_bank[bad]);
    end
  endtask

  // Presents one beat until accepted (bounded); returns on posedge+1.
  task automatic send_beat(input logic [15:0] v, input bit with_abort);
    bit acc;
    acc = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_coeff = v;
    bus.abort   = with_abort;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    bus.abort   = 1'b0;
    if (!acc) check("beat_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic do_load(input vec_t v, input int ck_delta, input string name);
    logic [15:0] sum;
    logic [15:0] val;
    bit          aborted;
    bit          commit;
    bit          exp_err;
    int          upd0;
    int          err0;
    sum     = '0;
    aborted = 1'b0;
    upd0    = upd_cnt;
    err0    = err_cnt;
    pulse_start();
    @(negedge clk);
    check({name, "_busy_in_load"}, 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < NT; k++) begin
      if (v.gap) begin
        @(posedge clk);
        #1;
      end
      if (v.abort_mode == 1 && k == v.abort_k) begin
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        aborted = 1'b1;
        break;
      end
      val = 16'(int'(v.first) + k * int'(v.step));
      send_beat(val, v.abort_mode == 2 && k == v.abort_k);
      sum = sum + val;
      if (v.abort_mode == 2 && k == v.abort_k) begin
        aborted = 1'b1;
        break;
      end
    end
    exp_err = 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
    if (!aborted) begin
      send_beat(16'(int'(sum) + ck_delta), 1'b0);
      exp_err = (ck_delta != 0);
    end
`endif
    commit = v.exp_commit && !aborted && (ck_delta == 0);
    @(negedge clk);
    check({name, "_update_strobe"}, 32'(bus.update_coeff), 32'(commit));
    check({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({name, "_err"}, 32'(bus.err), 32'(exp_err));
    @(negedge clk);
    check({name, "_update_one_cycle"}, 32'(bus.update_coeff), 32'd0);
    check({name, "_update_count"}, 32'(upd_cnt - upd0), 32'(commit));
    check({name, "_err_count"}, 32'(err_cnt - err0), 32'(exp_err));
    if (commit)
      for (int k = 0; k < NT; k++) exp_bank[k] = 16'(int'(v.first) + k * int'(v.step));
    check_bank({name, "_bank"});
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    upd_cnt     = 0;
    err_cnt     = 0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_coeff = '0;
    for (int k = 0; k < NT; k++) exp_bank[k] = '0;

    vecs[0] = '{first: 16'd1,      step: 16'd1,      gap: 1'b0, abort_k: 0,  abort_mode: 0,
                exp_commit: 1'b1};
    vecs[1] = '{first: 16'd1,      step: 16'd1,      gap: 1'b1, abort_k: 0,  abort_mode: 0,
                exp_commit: 1'b1};
    vecs[2] = '{first: 16'hAAAA,   step: 16'd0,      gap: 1'b0, abort_k: 20, abort_mode: 1,
                exp_commit: 1'b0};
    vecs[3] = '{first: 16'h0100,   step: 16'd0,      gap: 1'b0, abort_k: 0,  abort_mode: 0,
                exp_commit: 1'b1};
    vecs[4] = '{first: 16'h0500,   step: 16'd3,      gap: 1'b0, abort_k: 40, abort_mode: 2,
                exp_commit: 1'b0};
    vecs[5] = '{first: 16'hFFF0,   step: 16'h0011,   gap: 1'b1, abort_k: 0,  abort_mode: 0,
                exp_commit: 1'b1};

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_update", 32'(bus.update_coeff), 32'd0);
    check("rst_ready", 32'(bus.s_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check_bank("rst_bank");

    // Beats offered while idle are dropped
    @(posedge clk);
    #1 bus.s_valid = 1'b1;
    bus.s_coeff = 16'hFFFF;
    @(negedge clk);
    check("idle_ready", 32'(bus.s_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 bus.s_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // start with abort in idle stays idle
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 6; i++) do_load(vecs[i], 0, $sformatf("vec%0d", i));

    // Reset in the middle of a load
    pulse_start();
    for (int k = 0; k < 30; k++) send_beat(16'(100 + k), 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < NT; k++) exp_bank[k] = '0;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_ready", 32'(bus.s_ready), 32'd0);
    check_bank("midrst_bank");
    do_load(vecs[0], 0, "after_rst");

`ifdef FIR_COEFF_CHECKSUM_EN
    // Checksum of 1..41 is 0x035D; 0x035C must be rejected
    do_load(vecs[3], 0, "ck_prep");
    do_load(vecs[0], 0, "ck_good");
    do_load(vecs[3], 0, "ck_prep2");
    do_load(vecs[0], -1, "ck_bad");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
